clk_branch_seq: RTL and testbench
=================================

# clk_branch_seq

Staggered enable sequencer for the eight leaf branches of the `jpeg_encoder` clock tree, i.e. the third-level `clkbuf_3_*` buffers. It drives one clock-gate enable per branch and turns branches on and off one at a time, a fixed number of cycles apart, to bound supply di/dt at encoder start and stop. It sits outside the gated domain on the root clock. It is the only agent permitted to drive the branch clock-gate enables.

## Interface
Parameters:
- `NUM_BRANCHES`, 8: number of gated leaf branches; legal range 2..16.
- `STAGGER`, 4: cycles between consecutive branch enable or disable events; legal range 1..255.
- `IDLE_CYCLES`, 64: count of consecutive inactive cycles in ON that triggers auto power-down; legal range 2..65535.

Ports:
- `clk`, input, 1: root clock, ungated; all state is on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `run_req`, input, 1: encoder requests its clocks; level-sensitive.
- `activity`, input, 1: encoder pipeline has valid data this cycle.
- `branch_en`, output, `NUM_BRANCHES`: registered clock-gate enables; bit k gates branch k.
- `all_on`, output, 1: registered; high exactly when the state is ON.
- `all_off`, output, 1: registered; high exactly when the state is OFF.

## Operation
State machine states: OFF, RAMP_UP, ON, RAMP_DOWN.
- `branch_en` is always thermometer-coded from bit 0 upward, and only one bit changes per event.
- A stagger counter of width clog2(STAGGER+1) reloads to 0 on every state entry and on every set or clear event.

OFF:
- `branch_en` is 0 and `all_off` is 1.
- `run_req` = 1 sampled (and not parked) → RAMP_UP; `branch_en[0]` sets at that same edge.

RAMP_UP:
- After every STAGGER cycles, the next unset bit sets.
- The edge that sets bit NUM_BRANCHES-1 also enters ON and sets `all_on`.
- `run_req` = 0 sampled → RAMP_DOWN; the highest set bit clears at that same edge.

ON:
- `branch_en` is all ones.
- `run_req` = 0 → RAMP_DOWN; bit NUM_BRANCHES-1 clears at that same edge, and `all_on` falls at that edge.

RAMP_DOWN:
- After every STAGGER cycles, the highest set bit clears.
- The edge that clears bit 0 also enters OFF and sets `all_off`.
- `run_req` = 1 sampled (and not parked) → RAMP_UP; the lowest unset bit sets at that same edge.

Simultaneous events and boundaries:
- A reversal mid-ramp resumes from the current thermometer position. No bit is ever skipped or toggled twice in one cycle.
- `activity` is ignored outside ON, except for clearing the park flag (see Configuration).

Reset:
- `rst` asserted at any time, including mid-ramp, forces OFF, `branch_en` = 0, `all_off` = 1, `all_on` = 0, all counters 0, and the park flag 0, immediately and asynchronously.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Edge 0 is the edge at which `run_req` = 1 is first sampled in OFF.
- Branch k sets at edge k·STAGGER.
- With defaults: bit 0 at edge 0, bit 7 and `all_on` at edge 28; full ramp-up latency is (NUM_BRANCHES-1)·STAGGER + 1 cycles.
- Ramp-down is symmetric: from ON, `all_off` rises 28 edges after the first clear with defaults.
- With STAGGER = 1, one bit changes every cycle.
- The idle counter has width clog2(IDLE_CYCLES+1) and saturates at IDLE_CYCLES.

## Configuration
Macro: `CLK_BRANCH_IDLE_OFF_EN`.

Defined:
- In ON, the idle counter increments on every cycle with `activity` = 0 and clears to 0 on `activity` = 1.
- Reaching IDLE_CYCLES → RAMP_DOWN, and the park flag sets.
- While parked, `run_req` = 1 does not trigger RAMP_UP.
- `activity` = 1, or `run_req` = 0, clears the park flag. If `run_req` is still 1 when the flag clears, RAMP_UP starts at that edge.

Undefined:
- No idle counter and no park flag.
- `activity` is unused.
- Ramp-down happens only on `run_req` = 0.

## Test plan
- Reset, then `run_req` = 1 held → `branch_en` steps 0x01, 0x03, …, 0xFF at edges 0, 4, …, 28; `all_on` = 1 at edge 28; `all_off` = 0 from edge 0.
- In ON, drop `run_req` → `branch_en` steps 0x7F, 0x3F, …, 0x00 at 4-cycle intervals; `all_on` falls at the first clear; `all_off` rises with the 0x00 edge.
- Drop `run_req` at `branch_en` = 0x07 during RAMP_UP → 0x03 at that edge, then 0x01 and 0x00 at +4 and +8. Raise `run_req` again at 0x01 → 0x03 at that edge.
- Assert `rst` asynchronously at `branch_en` = 0x1F → outputs reach 0x00, `all_off` = 1, `all_on` = 0 before the next edge. Release with `run_req` = 1 → normal ramp from 0x01.
- With `CLK_BRANCH_IDLE_OFF_EN`, in ON with `activity` = 0 for 64 cycles → ramp-down begins at the 64th edge. Hold `run_req` = 1 → stays OFF. Pulse `activity` = 1 → ramp-up starts at that edge.
- With STAGGER = 1 and NUM_BRANCHES = 2 → `branch_en` goes 0x1 then 0x3 on consecutive edges, and `all_on` is high at the second edge.

Source files
------------

// File: rtl/clk_branch_seq.sv
// clk_branch_seq: staggered thermometer sequencer for the leaf clock-gate enables of the jpeg_encoder clock tree
// Ports: clk (root clock), rst (async, active-high), run_req (clock request level), activity (pipeline busy),
//        branch_en[NUM_BRANCHES] (registered gate enables), all_on / all_off (registered state flags).
// Optional: define CLK_BRANCH_IDLE_OFF_EN to power the branches down after IDLE_CYCLES inactive cycles in ON.
module clk_branch_seq #(
  parameter int NUM_BRANCHES = 8,
  parameter int STAGGER = 4,
  parameter int IDLE_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run_req,
  input  logic activity,
  output logic [NUM_BRANCHES-1:0] branch_en,
  output logic all_on,
  output logic all_off
);
  localparam int SW = $clog2(STAGGER + 1);
  typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] cnt, cnt_nxt;
  logic [NUM_BRANCHES-1:0] en_nxt;
  logic go, idle_hit, tick, up, dn;
`ifdef CLK_BRANCH_IDLE_OFF_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  logic [IW-1:0] idle, idle_nxt;
  logic park, park_nxt;
  // a parked sequencer ignores run_req until activity returns or the request drops
  always_comb begin
    idle_nxt = (state != ON || activity) ? '0 : (idle == IW'(IDLE_CYCLES)) ? idle : idle + 1'b1;
    idle_hit = state == ON && run_req && idle_nxt == IW'(IDLE_CYCLES);
    go = run_req && (!park || activity);
    park_nxt = idle_hit || (park && run_req && !activity);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idle <= '0;
      park <= 1'b0;
    end else begin
      idle <= idle_nxt;
      park <= park_nxt;
    end
`else
  logic unused;
  assign unused = activity;
  assign go = run_req;
  assign idle_hit = 1'b0;
`endif
  // one bit moves per event; the resulting thermometer value decides whether a ramp has completed
  always_comb begin
    tick = cnt == SW'(STAGGER - 1);
    up = go && (state == OFF || state == RAMP_DOWN || (state == RAMP_UP && tick));
    dn = (state == RAMP_UP && !go) || (state == ON && (!run_req || idle_hit)) || (state == RAMP_DOWN && !go && tick);
    en_nxt = up ? {branch_en[NUM_BRANCHES-2:0], 1'b1} : dn ? branch_en >> 1 : branch_en;
    state_nxt = !(up || dn) ? state : &en_nxt ? ON : ~|en_nxt ? OFF : up ? RAMP_UP : RAMP_DOWN;
    cnt_nxt = (up || dn || state == OFF || state == ON) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= OFF;
      branch_en <= '0;
      cnt <= '0;
      all_on <= 1'b0;
      all_off <= 1'b1;
    end else begin
      state <= state_nxt;
      branch_en <= en_nxt;
      cnt <= cnt_nxt;
      all_on <= state_nxt == ON;
      all_off <= state_nxt == OFF;
    end
endmodule

// File: tb/tb_clk_branch_seq.sv
// tb_clk_branch_seq: scoreboard bench for clk_branch_seq with a level/timer reference model
module tb_clk_branch_seq;
  localparam int N = 8, S = 4, I = 64;
  logic clk = 1'b0, rst, run_req, activity, run1;
  logic [N-1:0] branch_en;
  logic all_on, all_off, on1, off1;
  logic [1:0] be1;
  int n_chk = 0, n_err = 0;
  int lvl, t, mst, idle;
  bit park;
  logic [N+1:0] sb[$];
  always #5 clk = ~clk;
  clk_branch_seq #(.NUM_BRANCHES(N), .STAGGER(S), .IDLE_CYCLES(I)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .activity(activity),
    .branch_en(branch_en), .all_on(all_on), .all_off(all_off));
  clk_branch_seq #(.NUM_BRANCHES(2), .STAGGER(1), .IDLE_CYCLES(I)) dut1 (
    .clk(clk), .rst(rst), .run_req(run1), .activity(1'b0),
    .branch_en(be1), .all_on(on1), .all_off(off1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    lvl = 0; t = 0; mst = 0; idle = 0; park = 0;
  endtask
  // mst: 0 off, 1 ramping up, 2 on, 3 ramping down; lvl counts enabled branches
  task automatic model(input logic r, input logic a);
    int d;
    bit go, hit;
    d = 0; hit = 0;
`ifdef CLK_BRANCH_IDLE_OFF_EN
    go = r && (!park || a);
`else
    go = r;
`endif
    case (mst)
      0: if (go) d = 1;
      1: if (!go) d = -1; else if (t == S - 1) d = 1;
      2: if (!r) d = -1;
`ifdef CLK_BRANCH_IDLE_OFF_EN
         else begin
           idle = a ? 0 : (idle < I ? idle + 1 : idle);
           if (idle == I) begin d = -1; hit = 1; end
         end
`endif
      default: if (go) d = 1; else if (t == S - 1) d = -1;
    endcase
`ifdef CLK_BRANCH_IDLE_OFF_EN
    park = hit || (park && r && !a);
`endif
    if (d != 0) begin
      lvl += d; t = 0;
      mst = lvl == N ? 2 : lvl == 0 ? 0 : d > 0 ? 1 : 3;
    end else t = (mst == 1 || mst == 3) ? t + 1 : 0;
    if (mst != 2) idle = 0;
  endtask
  task automatic step(input logic r, input logic a);
    logic [N+1:0] e;
    int v;
    run_req = r; activity = a;
    model(r, a);
    v = (1 << lvl) - 1;
    sb.push_back({v[N-1:0], mst == 2, mst == 0});
    @(posedge clk); #1;
    e = sb.pop_front();
    check("branch_en", branch_en, e[N+1:2]);
    check("all_on", all_on, e[1]);
    check("all_off", all_off, e[0]);
  endtask
  initial begin
    int first;
    logic r;
    rst = 1'b1; run_req = 1'b0; activity = 1'b0; run1 = 1'b0;
    model_reset();
    #3;
    check("rst_en", branch_en, 0);
    check("rst_off", all_off, 1);
    check("rst_on", all_on, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run1 = 1'b1;
    @(posedge clk); #1;
    check("s1_first", be1, 2'b01);
    check("s1_off", off1, 0);
    @(posedge clk); #1;
    check("s1_second", be1, 2'b11);
    check("s1_on", on1, 1);
    first = -1;
    for (int i = 0; i < 29; i++) begin
      step(1'b1, 1'b0);
      if (i % S == 0) check("ramp_up", branch_en, (1 << (i / S + 1)) - 1);
      if (i == 0) check("off_low", all_off, 0);
      if (all_on && first < 0) first = i;
    end
    check("on_edge", first, 28);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    first = -1;
    for (int i = 0; i < 29; i++) begin
      step(1'b0, 1'b0);
      if (i % S == 0) check("ramp_dn", branch_en, 32'hFF >> (i / S + 1));
      if (i == 0) check("on_fall", all_on, 0);
      if (all_off && first < 0) first = i;
    end
    check("off_edge", first, 28);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    check("rev_at7", branch_en, 8'h07);
    step(1'b0, 1'b0);
    check("rev_03", branch_en, 8'h03);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("rev_01", branch_en, 8'h01);
    step(1'b1, 1'b0);
    check("rev_up", branch_en, 8'h03);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    check("drained", all_off, 1);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0);
    check("pre_rst", branch_en, 8'h1F);
    #2 rst = 1'b1;
    #1;
    check("arst_en", branch_en, 0);
    check("arst_off", all_off, 1);
    check("arst_on", all_on, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 1'b0);
    check("post_rst", branch_en, 8'h01);
`ifdef CLK_BRANCH_IDLE_OFF_EN
    for (int i = 0; i < 100 && !all_on; i++) step(1'b1, 1'b1);
    check("idle_on", all_on, 1);
    for (int i = 0; i < 63; i++) step(1'b1, 1'b0);
    check("idle_hold", branch_en, 8'hFF);
    step(1'b1, 1'b0);
    check("idle_dn", branch_en, 8'h7F);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
    check("parked", all_off, 1);
    step(1'b1, 1'b1);
    check("unpark", branch_en, 8'h01);
`endif
    r = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0) r = ~r;
      step(r, 1'($urandom_range(1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
